// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, RAM read requests, prefetch FIFO and branch redirect.
// Presents fetched words to decode through a valid/ready handshake.
module instr_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic        Mem_Enable,
    output logic        Mem_RW,
    output logic [15:0] Mem_Address,
    input  logic [31:0] Mem_Data,
    output logic [31:0] Instr,
    output logic [15:0] Instr_PC,
    output logic        Instr_Valid,
    input  logic        Instr_Ready,
    input  logic        Branch_Taken,
    input  logic [15:0] Branch_Target
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   pc_q, pc_d;
    logic          mem_en_q, mem_en_d;
    logic [15:0]   mem_addr_q, mem_addr_d;
    logic          mem_rw_q;
    logic          kill_q, kill_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   data_q [DEPTH];
    logic [15:0]   addr_q [DEPTH];

    logic          push;
    logic          pop;
    logic          issue;
    logic [CW-1:0] count_next;

    // Handshake: a word transfers at an edge where Instr_Valid && Instr_Ready;
    // Instr/Instr_PC hold steady while Instr_Valid is high and Instr_Ready is low.
    assign Instr_Valid = (count_q != '0);
    assign Instr       = Instr_Valid ? data_q[rd_ptr_q] : 32'h0;
    assign Instr_PC    = Instr_Valid ? addr_q[rd_ptr_q] : 16'h0;
    assign Mem_Enable  = mem_en_q;
    assign Mem_Address = mem_addr_q;
    assign Mem_RW      = mem_rw_q;

    always_comb begin
        pop        = Instr_Valid && Instr_Ready && !Branch_Taken;
        push       = mem_en_q && !kill_q && !Branch_Taken;
        count_next = count_q + CW'(push) - CW'(pop);
        // The word requested now lands next cycle, so it needs a free slot after this edge.
        issue      = !Branch_Taken && (count_next < CW'(DEPTH));

        pc_d       = pc_q;
        mem_en_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        kill_d     = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_next;

        if (Branch_Taken) begin
            pc_d     = Branch_Target;
            kill_d   = mem_en_q;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (issue) begin
                mem_en_d   = 1'b1;
                mem_addr_d = pc_q;
                pc_d       = pc_q + 16'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q       <= RESET_PC;
            mem_en_q   <= 1'b0;
            mem_addr_q <= 16'h0000;
            mem_rw_q   <= 1'b1;
            kill_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            mem_en_q   <= mem_en_d;
            mem_addr_q <= mem_addr_d;
            mem_rw_q   <= 1'b1;
            kill_q     <= kill_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted as occupied.
    always_ff @(posedge Clk) begin
        if (!Reset && push) begin
            data_q[wr_ptr_q] <= Mem_Data;
            addr_q[wr_ptr_q] <= mem_addr_q;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomised
// ready/branch traffic checked against an in-order delivery model.
module tb_instr_fetch_unit;

  localparam int DEPTH = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] WRAP_PC = 16'hFFFE;

  logic clk;
  logic reset;
  logic mem_en, mem_rw;
  logic [15:0] mem_addr;
  logic [31:0] mem_data;
  logic [31:0] instr;
  logic [15:0] instr_pc;
  logic instr_valid, instr_ready;
  logic branch_taken;
  logic [15:0] branch_target;

  logic rst_w;
  logic mem_en_w, mem_rw_w;
  logic [15:0] mem_addr_w;
  logic [31:0] mem_data_w;
  logic [31:0] instr_w;
  logic [15:0] instr_pc_w;
  logic instr_valid_w;

  int n_pass = 0;
  int n_total = 0;

  logic [15:0] exp_pc;
  logic [15:0] exp_issue;
  int outstanding;
  int pops;
  int issues;

  function automatic logic [31:0] ram_word(input logic [15:0] a);
    return 32'hA000_0000 + {16'h0, a};
  endfunction

  // RAM holds its address register in Mem_Address; data follows one cycle after the request edge.
  assign mem_data   = mem_en ? ram_word(mem_addr) : 32'hDEAD_BEEF;
  assign mem_data_w = mem_en_w ? ram_word(mem_addr_w) : 32'hDEAD_BEEF;

  instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .Clk(clk), .Reset(reset),
    .Mem_Enable(mem_en), .Mem_RW(mem_rw), .Mem_Address(mem_addr), .Mem_Data(mem_data),
    .Instr(instr), .Instr_PC(instr_pc), .Instr_Valid(instr_valid), .Instr_Ready(instr_ready),
    .Branch_Taken(branch_taken), .Branch_Target(branch_target)
  );

  instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(WRAP_PC)) dut_w (
    .Clk(clk), .Reset(rst_w),
    .Mem_Enable(mem_en_w), .Mem_RW(mem_rw_w), .Mem_Address(mem_addr_w), .Mem_Data(mem_data_w),
    .Instr(instr_w), .Instr_PC(instr_pc_w), .Instr_Valid(instr_valid_w), .Instr_Ready(1'b1),
    .Branch_Taken(1'b0), .Branch_Target(16'h0000)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  // One clock edge; the model predicts delivery order and issue addresses from
  // what the inputs requested before the edge.
  task automatic step();
    logic pop_now, hold_now, br_now, rst_now;
    logic [31:0] ins;
    logic [15:0] ipc, tgt;
    pop_now  = instr_valid && instr_ready;
    hold_now = instr_valid && !instr_ready;
    br_now   = branch_taken;
    rst_now  = reset;
    ins      = instr;
    ipc      = instr_pc;
    tgt      = branch_target;
    @(posedge clk);
    #1;
    check("mem_rw", {31'h0, mem_rw}, 32'h1);
    if (rst_now) begin
      exp_pc = RESET_PC;
      exp_issue = RESET_PC;
      outstanding = 0;
      check("reset_valid", {31'h0, instr_valid}, 32'h0);
      check("reset_mem_en", {31'h0, mem_en}, 32'h0);
    end else if (br_now) begin
      exp_pc = tgt;
      exp_issue = tgt;
      outstanding = 0;
      check("redirect_valid", {31'h0, instr_valid}, 32'h0);
      check("redirect_mem_en", {31'h0, mem_en}, 32'h0);
    end else begin
      if (pop_now) begin
        check("pop_pc", {16'h0, ipc}, {16'h0, exp_pc});
        check("pop_instr", ins, ram_word(exp_pc));
        exp_pc = exp_pc + 16'd1;
        outstanding--;
        pops++;
      end
      if (hold_now) begin
        check("hold_valid", {31'h0, instr_valid}, 32'h1);
        check("hold_instr", instr, ins);
        check("hold_pc", {16'h0, instr_pc}, {16'h0, ipc});
      end
      if (mem_en) begin
        check("issue_addr", {16'h0, mem_addr}, {16'h0, exp_issue});
        exp_issue = exp_issue + 16'd1;
        outstanding++;
        issues++;
      end
      check("occupancy_bound", {31'h0, (outstanding <= DEPTH)}, 32'h1);
    end
  endtask

  initial begin
    reset = 1'b1;
    rst_w = 1'b1;
    instr_ready = 1'b0;
    branch_taken = 1'b0;
    branch_target = 16'h0000;
    exp_pc = RESET_PC;
    exp_issue = RESET_PC;
    outstanding = 0;
    pops = 0;
    issues = 0;

    // PC wrap from RESET_PC=FFFE on the second instance
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_w = 1'b0;
    @(posedge clk); #1;
    check("wrap_first_req", {15'h0, mem_en_w, mem_addr_w}, {15'h0, 1'b1, WRAP_PC});
    for (int k = 0; k < 4; k++) begin
      logic [15:0] wpc;
      @(posedge clk); #1;
      wpc = WRAP_PC + 16'(k);
      check("wrap_valid", {31'h0, instr_valid_w}, 32'h1);
      check("wrap_pc", {16'h0, instr_pc_w}, {16'h0, wpc});
      check("wrap_instr", instr_w, ram_word(wpc));
    end
    rst_w = 1'b1;

    // Reset values and first-fetch latency, then streaming
    step();
    check("reset_instr", instr, 32'h0);
    check("reset_instr_pc", {16'h0, instr_pc}, 32'h0);
    check("reset_mem_addr", {16'h0, mem_addr}, 32'h0);
    reset = 1'b0;
    instr_ready = 1'b1;
    step();
    check("first_req", {31'h0, mem_en}, 32'h1);
    check("first_valid_low", {31'h0, instr_valid}, 32'h0);
    step();
    check("first_valid", {31'h0, instr_valid}, 32'h1);
    check("first_pc", {16'h0, instr_pc}, {16'h0, RESET_PC});
    for (int i = 0; i < 8; i++) begin
      step();
      check("stream_valid", {31'h0, instr_valid}, 32'h1);
    end

    // Backpressure: FIFO fills to exactly DEPTH requests
    reset = 1'b1;
    instr_ready = 1'b0;
    step();
    reset = 1'b0;
    pops = 0;
    issues = 0;
    for (int i = 0; i < 10; i++) step();
    check("bp_issue_count", issues, DEPTH);
    check("bp_mem_en_low", {31'h0, mem_en}, 32'h0);
    check("bp_head_instr", instr, ram_word(16'h0000));
    check("bp_head_pc", {16'h0, instr_pc}, 32'h0);
    instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check("bp_drain_pops", pops, 8);

    // Redirect while a request is in flight
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("br_inflight", {31'h0, mem_en}, 32'h1);
    branch_taken = 1'b1;
    branch_target = 16'h0040;
    step();
    branch_taken = 1'b0;
    step();
    check("br_valid_r1", {31'h0, instr_valid}, 32'h0);
    step();
    check("br_valid_r2", {31'h0, instr_valid}, 32'h1);
    check("br_target_pc", {16'h0, instr_pc}, 32'h0040);
    for (int i = 0; i < 4; i++) step();

    // Randomised ready with occasional redirects
    reset = 1'b1;
    step();
    reset = 1'b0;
    pops = 0;
    for (int i = 0; i < 200; i++) begin
      instr_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) begin
        branch_taken = 1'b1;
        branch_target = 16'($urandom_range(0, 65535));
      end else begin
        branch_taken = 1'b0;
      end
      step();
    end
    branch_taken = 1'b0;
    check("rand_progress", {31'h0, (pops >= 40)}, 32'h1);

    // Reset mid-stream with a request in flight
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("mid_inflight", {31'h0, mem_en}, 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    check("mid_restart_req", {16'h0, mem_addr}, {16'h0, RESET_PC});
    step();
    check("mid_restart_valid", {31'h0, instr_valid}, 32'h1);
    check("mid_restart_pc", {16'h0, instr_pc}, {16'h0, RESET_PC});
    for (int i = 0; i < 4; i++) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
